mem_port_arbiter_64: RTL and testbench
======================================

Name: mem_port_arbiter_64

Overview:
Two-requester arbiter sharing one 64-bit memory port between instruction fetch (requester 0) and load/store (requester 1).
- Owns the port-select signal that steers the shared 64-bit request/write-data path through the 2-to-1 muxes.
- Sequences one outstanding memory transaction at a time and routes the response back to the winning requester.
- Sits between the fetch/LSU stages and the single-ported memory model.

Parameters:
- ADDR_W, 64, address width of requesters and memory port
- DATA_W, 64, read/write data width

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req0  input  1  requester 0 request valid
- i_addr0  input  ADDR_W  requester 0 address
- i_wdata0  input  DATA_W  requester 0 write data
- i_we0  input  1  requester 0 write enable
- o_gnt0  output  1  requester 0 request accepted this cycle
- o_done0  output  1  requester 0 transaction complete, one-cycle pulse
- i_req1, i_addr1, i_wdata1, i_we1, o_gnt1, o_done1  same as requester 0, for requester 1
- o_rdata  output  DATA_W  registered read data, valid with o_done0/o_done1
- o_sel  output  1  current/last granted requester, drives the mux select
- o_mem_req  output  1  memory request, held until ack
- o_mem_addr  output  ADDR_W  latched address
- o_mem_wdata  output  DATA_W  latched write data
- o_mem_we  output  1  latched write enable
- i_mem_ack  input  1  memory completes the request this cycle
- i_mem_rdata  input  DATA_W  memory read data, valid with i_mem_ack

Behaviour:
- Clock and reset: single clock i_clk; i_rst_n is asynchronous assert, synchronous release.
- Reset: state=IDLE, last_winner=1, o_sel=0, and all of the following are 0: o_mem_req, o_mem_addr, o_mem_wdata, o_mem_we, o_rdata, o_done0/1. o_gnt0/1=0 follows from IDLE with no request.
- FSM states: IDLE, BUSY.
- IDLE, no request: stay in IDLE.
- IDLE, request present: winner chosen combinationally.
  - Only one requester active: that requester wins.
  - Both active: winner = ~last_winner (round-robin).
  - o_gnt<winner>=1 in the same cycle; o_gnt is only ever high in IDLE.
  - On the clock edge: latch winner's addr/wdata/we into o_mem_*, o_sel<=winner, o_mem_req<=1, state<=BUSY.
- Handshake: a transfer occurs when req && gnt. The requester must drop or change req after its gnt. Requests during BUSY are held off (gnt=0).
- BUSY, i_mem_ack=0: hold o_mem_req and o_mem_* stable.
- BUSY, i_mem_ack=1: on the edge, o_rdata<=i_mem_rdata (reads and writes alike), o_done<o_sel><=1 for one cycle, o_mem_req<=0, last_winner<=o_sel, state<=IDLE.
- Back-to-back: a new grant is possible in the same cycle done is high.
- Latency: gnt at cycle t; o_mem_req at t+1; ack at t+k (k>=1) gives done and o_rdata at t+k+1. Minimum gnt-to-done is 2 cycles.
- Throughput: at most one transaction per 2 cycles.
- o_sel holds its value in IDLE (no change without a grant).
- i_mem_ack in IDLE: ignored, no done and no rdata update.
- Reset mid-transaction: outstanding transaction dropped, no done issued, FSM returns to IDLE.
- o_done0 and o_done1 are never high together. o_gnt0 and o_gnt1 are never high together.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: requester 1 (data) always wins when both request. last_winner is still updated but not used for the decision.
- Undefined: round-robin as described above.

Test Plan:
- Reset with i_rst_n=0, then release → all outputs 0, o_sel=0, state IDLE, no gnt with no requests.
- Single read: req0=1, addr0=0x1000 at t → gnt0=1 at t; o_mem_req=1, o_mem_addr=0x1000, o_sel=0 at t+1; ack at t+3 with rdata=0xDEADBEEF_CAFEF00D → o_done0=1 and o_rdata=0xDEADBEEF_CAFEF00D at t+4.
- Contention (round-robin): req0 and req1 held high continuously, ack 1 cycle after each o_mem_req → grants alternate 0,1,0,1; no done overlap.
- Write path: req1=1, we1=1, addr1=0x20, wdata1=0x55 → o_mem_we=1, o_mem_wdata=0x55 until ack; then o_done1 pulses once.
- Busy hold-off and stray ack: req0 asserted while BUSY for requester 1 → gnt0=0 until done1 cycle, then gnt0=1; a separate ack pulse driven in IDLE → no done, o_rdata unchanged.
- Reset mid-op: assert i_rst_n=0 during BUSY → o_mem_req drops immediately (asynchronous), no o_done ever issued for the dropped transaction. With ARB_FIXED_PRIO_EN defined, both requesting → gnt1 every time.

Source files
------------

// File: rtl/mem_port_arbiter_64.sv
// mem_port_arbiter_64: two-requester arbiter for one shared memory port.
// Requester 0 is instruction fetch and requester 1 is load/store.
// Only one transaction is outstanding at a time. The response is routed
// back to whichever requester won the grant.
// Optional build macro ARB_FIXED_PRIO_EN: when both requesters ask in the
// same cycle, requester 1 always wins. Without the macro, ties alternate
// round-robin on last_winner.
`timescale 1ns/1ps
module mem_port_arbiter_64 #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic              i_we0,
  output logic              o_gnt0,
  output logic              o_done0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic              i_we1,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_sel,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Latched request as presented to the memory port
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } mreq_t;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              mem_req_q, mem_req_d;
  mreq_t             mreq_q, mreq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        gnt;
  logic [1:0]        req_vec;
  logic              tie_winner;
  logic              winner;

`ifdef ARB_FIXED_PRIO_EN
  // Load/store always wins a tie. last_winner is still tracked but is not used here.
  assign tie_winner = 1'b1;
`else
  // Round-robin: a tie goes to whichever requester did not win last time.
  assign tie_winner = ~last_q;
`endif

  // Pick the winner among the active requesters
  always_comb begin
    req_vec = {i_req1, i_req0};
    case (req_vec)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = tie_winner;
      default: winner = 1'b0;
    endcase
  end

  // Next-state logic: grant in IDLE, wait for the memory ack in BUSY
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    mem_req_d = mem_req_q;
    mreq_d    = mreq_q;
    rdata_d   = rdata_q;
    done_d    = 2'b00;
    gnt       = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          gnt[winner] = 1'b1;
          mreq_d      = winner ? '{addr: i_addr1, wdata: i_wdata1, we: i_we1}
                               : '{addr: i_addr0, wdata: i_wdata0, we: i_we0};
          sel_d       = winner;
          mem_req_d   = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          rdata_d       = i_mem_rdata;
          done_d[sel_q] = 1'b1;
          mem_req_d     = 1'b0;
          last_d        = sel_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset drops any transaction that is still outstanding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mreq_q    <= '0;
      rdata_q   <= '0;
      done_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      mem_req_q <= mem_req_d;
      mreq_q    <= mreq_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  assign o_gnt0      = gnt[0];
  assign o_gnt1      = gnt[1];
  assign o_done0     = done_q[0];
  assign o_done1     = done_q[1];
  assign o_rdata     = rdata_q;
  assign o_sel       = sel_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_addr  = mreq_q.addr;
  assign o_mem_wdata = mreq_q.wdata;
  assign o_mem_we    = mreq_q.we;

endmodule

// File: tb/tb_mem_port_arbiter_64.sv
// Self-checking bench for mem_port_arbiter_64.
// A transaction-level model predicts every output on each falling edge.
// Directed sequences also pin hand-computed values at specific cycles.
`timescale 1ns/1ps
module tb_mem_port_arbiter_64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [63:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, sel, mem_req, mem_we;
  logic [63:0] rdata, mem_addr, mem_wdata;
  logic        ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int done0_cnt = 0, done1_cnt = 0;
  logic gq[$];

  always #5 clk = ~clk;

  mem_port_arbiter_64 #(.ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_addr0(addr0), .i_wdata0(wdata0), .i_we0(we0),
    .o_gnt0(gnt0), .o_done0(done0),
    .i_req1(req1), .i_addr1(addr1), .i_wdata1(wdata1), .i_we1(we1),
    .o_gnt1(gnt1), .o_done1(done1),
    .o_rdata(rdata), .o_sel(sel), .o_mem_req(mem_req),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_ack(ack), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One outstanding transaction record plus the last response delivered.
  logic        m_busy, m_who, m_last, m_sel, m_we, m_done0, m_done1;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        exp_w;

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
`ifdef ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return ~last;
`endif
  endfunction

  assign exp_w = pick(req0, req1, m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_who <= 0; m_last <= 1; m_sel <= 0; m_we <= 0;
      m_done0 <= 0; m_done1 <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else begin
      m_done0 <= 0;
      m_done1 <= 0;
      if (m_busy) begin
        if (ack) begin
          m_busy  <= 0;
          m_rdata <= mem_rdata;
          m_last  <= m_who;
          if (m_who) m_done1 <= 1; else m_done0 <= 1;
        end
      end else if (req0 || req1) begin
        m_busy  <= 1;
        m_who   <= exp_w;
        m_sel   <= exp_w;
        m_addr  <= exp_w ? addr1 : addr0;
        m_wdata <= exp_w ? wdata1 : wdata0;
        m_we    <= exp_w ? we1 : we0;
      end
    end
  end

  // Compare the DUT against the model every cycle, and log grants and dones
  always @(negedge clk) begin
    chk("gnt0",  gnt0,  !m_busy && (req0 || req1) && exp_w == 1'b0);
    chk("gnt1",  gnt1,  !m_busy && (req0 || req1) && exp_w == 1'b1);
    chk("done0", done0, m_done0);
    chk("done1", done1, m_done1);
    chk("done_overlap", done0 & done1, 1'b0);
    chk("rdata", rdata, m_rdata);
    chk("sel", sel, m_sel);
    chk("mem_req", mem_req, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_we", mem_we, m_we);
    end
    if (gnt0) gq.push_back(1'b0);
    if (gnt1) gq.push_back(1'b1);
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a memory request, then ack it lat cycles later
  task automatic serve(input int lat, input logic [63:0] d);
    int n = 0;
    while (!mem_req && n < 50) begin cyc(); n++; end
    if (!mem_req) begin
      n_chk++; n_fail++;
      $display("FAIL serve_timeout: got no mem_req, expected one within 50 cycles");
    end
    repeat (lat - 1) cyc();
    ack = 1'b1; mem_rdata = d;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1;
    logic exp_q[$];

    // Reset
    rst_n = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt0_idle", gnt0, 1'b0);
    chk("rst_gnt1_idle", gnt1, 1'b0);
    chk("rst_mem_addr", mem_addr, 64'h0);

    // Single read from requester 0, acked 3 cycles after the grant
    cyc(); req0 = 1; addr0 = 64'h1000; we0 = 0;
    @(negedge clk); chk("rd_gnt0_t", gnt0, 1'b1);
    cyc(); req0 = 0;
    @(negedge clk);
    chk("rd_mem_req_t1", mem_req, 1'b1);
    chk("rd_mem_addr_t1", mem_addr, 64'h1000);
    chk("rd_sel_t1", sel, 1'b0);
    cyc();
    cyc(); ack = 1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk); chk("rd_done0_t3", done0, 1'b0);
    cyc(); ack = 0;
    @(negedge clk);
    chk("rd_done0_t4", done0, 1'b1);
    chk("rd_rdata_t4", rdata, 64'hDEADBEEF_CAFEF00D);

    // Contention from reset: ties alternate 0,1,0,1 (always 1 with fixed priority)
    cyc(); do_reset();
    gq.delete();
    req0 = 1; req1 = 1; addr0 = 64'hA0; addr1 = 64'hB0;
    for (int i = 0; i < 4; i++) serve(1, 64'h100 + 64'(i));
    req0 = 0; req1 = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    chk("rr_count", 64'(gq.size()), 64'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk($sformatf("rr_grant%0d", i), gq[i], exp_q[i]);

    // Write path from requester 1
    cyc(); cyc();
    d1 = done1_cnt;
    req1 = 1; we1 = 1; addr1 = 64'h20; wdata1 = 64'h55;
    @(negedge clk); chk("wr_gnt1", gnt1, 1'b1);
    cyc(); req1 = 0; we1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wr_mem_we", mem_we, 1'b1);
      chk("wr_mem_wdata", mem_wdata, 64'h55);
      chk("wr_mem_addr", mem_addr, 64'h20);
      cyc();
    end
    ack = 1; mem_rdata = 64'h77;
    cyc(); ack = 0;
    repeat (3) cyc();
    chk("wr_done1_once", 64'(done1_cnt - d1), 64'd1);

    // Busy hold-off: requester 0 asks while requester 1 is outstanding
    req1 = 1; addr1 = 64'h40;
    @(negedge clk); chk("ho_gnt1", gnt1, 1'b1);
    cyc(); req1 = 0; req0 = 1; addr0 = 64'h80;
    @(negedge clk); chk("ho_gnt0_busy_a", gnt0, 1'b0); chk("ho_sel1", sel, 1'b1);
    cyc();
    @(negedge clk); chk("ho_gnt0_busy_b", gnt0, 1'b0);
    cyc(); ack = 1; mem_rdata = 64'h1111;
    @(negedge clk); chk("ho_gnt0_busy_c", gnt0, 1'b0);
    cyc(); ack = 0;
    @(negedge clk);
    chk("ho_done1", done1, 1'b1);
    chk("ho_gnt0_b2b", gnt0, 1'b1);
    chk("ho_rdata", rdata, 64'h1111);
    cyc(); req0 = 0;
    @(negedge clk); chk("ho_sel0", sel, 1'b0); chk("ho_addr", mem_addr, 64'h80);
    ack = 1; mem_rdata = 64'h2222;
    cyc(); ack = 0;
    @(negedge clk); chk("ho_done0", done0, 1'b1); chk("ho_rdata2", rdata, 64'h2222);

    // Stray ack while IDLE must be ignored
    cyc(); ack = 1; mem_rdata = 64'h3333;
    cyc(); ack = 0;
    @(negedge clk);
    chk("stray_done0", done0, 1'b0);
    chk("stray_done1", done1, 1'b0);
    chk("stray_rdata", rdata, 64'h2222);

    // Reset in the middle of a transaction
    cyc(); req0 = 1; addr0 = 64'hC0;
    cyc(); req0 = 0;
    chk("mid_busy", mem_req, 1'b1);
    d1 = done0_cnt + done1_cnt;
    rst_n = 0; #1;
    chk("mid_req_drop_async", mem_req, 1'b0);
    cyc(); ack = 1; mem_rdata = 64'h4444;
    cyc(); ack = 0;
    rst_n = 1;
    repeat (3) cyc();
    chk("mid_no_done", 64'(done0_cnt + done1_cnt - d1), 64'd0);
    chk("mid_sel", sel, 1'b0);
    chk("mid_rdata", rdata, 64'h0);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
